// File: rtl/dcache_controller_if.sv
// Bus bundle between the D-cache controller, the MEM stage, the cache SRAM and data memory.
// master = controller side; slave = CPU/SRAM/memory side.
interface dcache_controller_if;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wr_data;
    logic         cpu_mem_read;
    logic         cpu_mem_write;
    logic [31:0]  cpu_rd_data;
    logic         cpu_stall;

    logic [3:0]   sram_addr;
    logic [24:0]  sram_wr_tag;
    logic [255:0] sram_wr_data;
    logic         sram_enable;
    logic         sram_write;
    logic [24:0]  sram_rd_tag;
    logic [255:0] sram_rd_data;
    logic         sram_hit;

    logic [31:0]  mem_addr;
    logic [255:0] mem_wr_data;
    logic         mem_enable;
    logic         mem_write;
    logic [255:0] mem_rd_data;
    logic         mem_ack;

    modport master (
        input  cpu_addr, cpu_wr_data, cpu_mem_read, cpu_mem_write,
        output cpu_rd_data, cpu_stall,
        output sram_addr, sram_wr_tag, sram_wr_data, sram_enable, sram_write,
        input  sram_rd_tag, sram_rd_data, sram_hit,
        output mem_addr, mem_wr_data, mem_enable, mem_write,
        input  mem_rd_data, mem_ack
    );

    modport slave (
        output cpu_addr, cpu_wr_data, cpu_mem_read, cpu_mem_write,
        input  cpu_rd_data, cpu_stall,
        input  sram_addr, sram_wr_tag, sram_wr_data, sram_enable, sram_write,
        output sram_rd_tag, sram_rd_data, sram_hit,
        input  mem_addr, mem_wr_data, mem_enable, mem_write,
        output mem_rd_data, mem_ack
    );
endinterface

// File: rtl/dcache_controller.sv
// Controller for a 2-way, 16-set, 32-byte-line write-back/write-allocate data cache.
// Serves hits in IDLE; on a miss writes back a dirty victim, refills the line and re-looks it up.
module dcache_controller (
    input  logic                clk,
    input  logic                rst_n,
    dcache_controller_if.master bus
);
    typedef enum logic [1:0] {StIdle, StWriteback, StReadmiss, StRefillDone} state_e;

    state_e       state_q, state_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [255:0] mem_data_q, mem_data_d;
    logic         mem_enable_q, mem_enable_d;
    logic         mem_write_q, mem_write_d;
    logic [22:0]  req_tag_q, req_tag_d;
    logic [3:0]   req_idx_q, req_idx_d;

    logic         req;
    logic         victim_dirty;
    logic [22:0]  cpu_tag;
    logic [3:0]   cpu_idx;
    logic [2:0]   cpu_word;
    logic [255:0] merged_line;
    logic         unused_addr_bits;

    assign req              = bus.cpu_mem_read | bus.cpu_mem_write;
    assign cpu_tag          = bus.cpu_addr[31:9];
    assign cpu_idx          = bus.cpu_addr[8:5];
    assign cpu_word         = bus.cpu_addr[4:2];
    assign victim_dirty     = (bus.sram_rd_tag[24:23] == 2'b11);
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign bus.sram_addr   = cpu_idx;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_data_q;
    assign bus.mem_enable  = mem_enable_q;
    assign bus.mem_write   = mem_write_q;

    always_comb begin
        merged_line = bus.sram_rd_data;
        merged_line[{cpu_word, 5'b0} +: 32] = bus.cpu_wr_data;
    end

    always_comb begin
        state_d          = state_q;
        mem_addr_d       = mem_addr_q;
        mem_data_d       = mem_data_q;
        mem_enable_d     = mem_enable_q;
        mem_write_d      = mem_write_q;
        req_tag_d        = req_tag_q;
        req_idx_d        = req_idx_q;
        bus.cpu_rd_data  = 32'h0;
        bus.cpu_stall    = 1'b1;
        bus.sram_enable  = 1'b0;
        bus.sram_write   = 1'b0;
        bus.sram_wr_tag  = {2'b10, req_tag_q};
        bus.sram_wr_data = bus.mem_rd_data;

        unique case (state_q)
            StIdle: begin
                bus.cpu_stall    = 1'b0;
                bus.sram_enable  = req;
                // Tag bits [22:0] double as the lookup key, so they are driven even for loads.
                bus.sram_wr_tag  = {{2{bus.cpu_mem_write}}, cpu_tag};
                bus.sram_wr_data = merged_line;
                if (req && bus.sram_hit) begin
                    if (bus.cpu_mem_read) begin
                        bus.cpu_rd_data = bus.sram_rd_data[{cpu_word, 5'b0} +: 32];
                    end
                    bus.sram_write = bus.cpu_mem_write;
                end else if (req) begin
                    bus.cpu_stall = 1'b1;
                    req_tag_d     = cpu_tag;
                    req_idx_d     = cpu_idx;
                    mem_enable_d  = 1'b1;
                    if (victim_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {bus.sram_rd_tag[22:0], cpu_idx, 5'b0};
                        mem_data_d  = bus.sram_rd_data;
                        state_d     = StWriteback;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = {cpu_tag, cpu_idx, 5'b0};
                        state_d     = StReadmiss;
                    end
                end
            end
            StWriteback: begin
                if (bus.mem_ack) begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = {req_tag_q, req_idx_q, 5'b0};
                    state_d     = StReadmiss;
                end
            end
            StReadmiss: begin
                if (bus.mem_ack) begin
                    bus.sram_enable = 1'b1;
                    bus.sram_write  = 1'b1;
                    mem_enable_d    = 1'b0;
                    state_d         = StRefillDone;
                end
            end
            StRefillDone: state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mem_addr_q   <= 32'h0;
            mem_data_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural SRAM and memory models, a word-level reference
// of memory contents and cache residency, directed vectors, random traffic and a reset corner.
module tb_dcache_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_controller_if bus ();
    dcache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // SRAM model: 2 ways per set, invalid way filled first, else LRU.
    logic [24:0]  s_tag [16][2];
    logic [255:0] s_dat [16][2];
    logic         s_lru [16];
    logic         sram_clr;
    logic         hit0, hit1, s_vic, s_way;

    always_comb begin
        hit0  = s_tag[bus.sram_addr][0][24] &&
                (s_tag[bus.sram_addr][0][22:0] == bus.sram_wr_tag[22:0]);
        hit1  = s_tag[bus.sram_addr][1][24] &&
                (s_tag[bus.sram_addr][1][22:0] == bus.sram_wr_tag[22:0]);
        s_vic = !s_tag[bus.sram_addr][0][24] ? 1'b0 :
                !s_tag[bus.sram_addr][1][24] ? 1'b1 : s_lru[bus.sram_addr];
        s_way = hit0 ? 1'b0 : hit1 ? 1'b1 : s_vic;
        bus.sram_hit     = hit0 | hit1;
        bus.sram_rd_tag  = s_tag[bus.sram_addr][s_way];
        bus.sram_rd_data = s_dat[bus.sram_addr][s_way];
    end

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 16; i++) begin
                s_lru[i] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_tag[i][w] <= '0;
                    s_dat[i][w] <= '0;
                end
            end
        end else if (bus.sram_enable && (bus.sram_hit || bus.sram_write)) begin
            if (bus.sram_write) begin
                s_tag[bus.sram_addr][s_way] <= bus.sram_wr_tag;
                s_dat[bus.sram_addr][s_way] <= bus.sram_wr_data;
            end
            s_lru[bus.sram_addr] <= ~s_way;
        end
    end

    // Backing memory (line granularity) and reference contents (word granularity).
    logic [255:0] mem_lines [int unsigned];
    logic [31:0]  ref_words [int unsigned];
    bit           ref_dirty [int unsigned];
    int unsigned  r_tag [16][2];
    int           r_cnt [16];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        int unsigned key = {a[31:2], 2'b00};
        if (ref_words.exists(key)) return ref_words[key];
        return init_word(a);
    endfunction

    function automatic logic [255:0] read_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4 * w));
        return l;
    endfunction

    // Cache residency as per-set MRU-ordered tag lists.
    task automatic ref_access(input bit st, input logic [31:0] a, input logic [31:0] d,
                              output bit hit, output bit wb, output logic [31:0] rd);
        int unsigned set = a[8:5];
        int unsigned t = a[31:9];
        int unsigned vline;
        hit = (r_cnt[set] > 0 && r_tag[set][0] == t) || (r_cnt[set] > 1 && r_tag[set][1] == t);
        wb = 1'b0;
        if (hit) begin
            if (r_tag[set][0] != t) begin
                r_tag[set][1] = r_tag[set][0];
                r_tag[set][0] = t;
            end
        end else begin
            if (r_cnt[set] == 2) begin
                vline = r_tag[set][1] * 16 + set;
                wb = ref_dirty.exists(vline) && ref_dirty[vline];
                ref_dirty[vline] = 1'b0;
            end else begin
                r_cnt[set]++;
            end
            r_tag[set][1] = r_tag[set][0];
            r_tag[set][0] = t;
        end
        rd = st ? 32'h0 : word_of(a);
        if (st) begin
            ref_words[{a[31:2], 2'b00}] = d;
            ref_dirty[a[31:5]] = 1'b1;
        end
    endtask

    // One CPU access, serving memory with lat_fix wait cycles (random when negative).
    task automatic access(input bit st, input logic [31:0] a, input logic [31:0] d,
                          input int lat_fix, output logic [31:0] rd, output int cyc);
        bit e_hit, e_wb, saw_wb;
        logic [31:0] e_rd;
        logic [255:0] exp_line;
        int lat, waited, exp_cyc;
        ref_access(st, a, d, e_hit, e_wb, e_rd);
        @(negedge clk);
        bus.cpu_addr = a;
        bus.cpu_wr_data = d;
        bus.cpu_mem_read = !st;
        bus.cpu_mem_write = st;
        lat = (lat_fix < 0) ? int'($urandom_range(0, 4)) : lat_fix;
        waited = 0;
        exp_cyc = 0;
        cyc = 0;
        saw_wb = 1'b0;
        forever begin
            #1;
            bus.mem_ack = 1'b0;
            if (!bus.cpu_stall) break;
            if (cyc > 100) begin
                fail_now("stall_timeout");
                break;
            end
            if (bus.mem_enable) begin
                if (waited == lat) begin
                    bus.mem_ack = 1'b1;
                    exp_cyc += lat + 1;
                    check("mem_addr_align", bus.mem_addr[4:0], 0);
                    if (bus.mem_write) begin
                        saw_wb = 1'b1;
                        mem_lines[bus.mem_addr] = bus.mem_wr_data;
                        for (int w = 0; w < 8; w++)
                            exp_line[32*w +: 32] = word_of(bus.mem_addr + 32'(4 * w));
                        check("wb_line", bus.mem_wr_data, exp_line);
                    end else begin
                        check("refill_addr", bus.mem_addr, {a[31:5], 5'b0});
                        bus.mem_rd_data = read_line(bus.mem_addr);
                        #1;
                        check("refill_sram_wr", {bus.sram_enable, bus.sram_write}, 2'b11);
                        check("refill_tag", bus.sram_wr_tag, {2'b10, a[31:9]});
                    end
                    waited = 0;
                    lat = (lat_fix < 0) ? int'($urandom_range(0, 4)) : lat_fix;
                end else begin
                    waited++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack = 1'b0;
        rd = bus.cpu_rd_data;
        if (cyc <= 100) begin
            check("hit_pred", cyc == 0, e_hit);
            check("wb_pred", saw_wb, e_wb);
            check("penalty", cyc, e_hit ? 0 : exp_cyc + 2);
            check("rdata_model", rd, e_rd);
            if (st) begin
                exp_line = bus.sram_rd_data;
                exp_line[32*a[4:2] +: 32] = d;
                check("store_write", bus.sram_write, 1'b1);
                check("store_tag", bus.sram_wr_tag, {2'b11, a[31:9]});
                check("store_line", bus.sram_wr_data, exp_line);
            end else begin
                check("load_no_write", bus.sram_write, 1'b0);
            end
        end
        @(posedge clk);
    endtask

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cyc;
        bool_seen: begin end
        bus.cpu_addr = 32'h0;
        bus.cpu_wr_data = 32'h0;
        bus.cpu_mem_read = 1'b0;
        bus.cpu_mem_write = 1'b0;
        bus.mem_rd_data = '0;
        bus.mem_ack = 1'b0;
        sram_clr = 1'b1;
        for (int i = 0; i < 16; i++) r_cnt[i] = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_enable", bus.mem_enable, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_data", bus.mem_wr_data, 256'h0);
        check("rst_stall", bus.cpu_stall, 1'b0);
        check("rst_sram_enable", bus.sram_enable, 1'b0);
        @(negedge clk);
        sram_clr = 1'b0;
        rst_n = 1'b1;

        tbl[0]  = '{0, 32'h0000_0040, 32'h0,         4, 32'h5A5A_0040, 7};
        tbl[1]  = '{0, 32'h0000_0040, 32'h0,         0, 32'h5A5A_0040, 0};
        tbl[2]  = '{1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 32'h0,         0};
        tbl[3]  = '{0, 32'h0000_0044, 32'h0,         0, 32'hDEAD_BEEF, 0};
        tbl[4]  = '{0, 32'h0000_0240, 32'h0,         1, 32'h5A5A_0240, 4};
        tbl[5]  = '{0, 32'h0000_0440, 32'h0,         2, 32'h5A5A_0440, 8};
        tbl[6]  = '{0, 32'h0000_0640, 32'h0,         0, 32'h5A5A_0640, 3};
        tbl[7]  = '{0, 32'h0000_0044, 32'h0,         3, 32'hDEAD_BEEF, 6};
        tbl[8]  = '{0, 32'h0000_0060, 32'h0,         0, 32'h5A5A_0060, 3};
        tbl[9]  = '{0, 32'h0000_027C, 32'h0,         0, 32'h5A5A_027C, 3};
        tbl[10] = '{0, 32'h0000_0060, 32'h0,         0, 32'h5A5A_0060, 0};
        tbl[11] = '{0, 32'h0000_027C, 32'h0,         0, 32'h5A5A_027C, 0};
        tbl[12] = '{0, 32'h0000_007C, 32'h0,         0, 32'h5A5A_007C, 0};
        tbl[13] = '{0, 32'h0000_0260, 32'h0,         0, 32'h5A5A_0260, 0};

        for (int i = 0; i < 14; i++) begin
            access(tbl[i].st, tbl[i].addr, tbl[i].wdata, tbl[i].lat, rd, cyc);
            check($sformatf("tbl_rdata[%0d]", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl_stall[%0d]", i), cyc, tbl[i].exp_stall);
        end

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 4)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            access($urandom_range(0, 1) == 1, a, $urandom, -1, rd, cyc);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.cpu_mem_read = 1'b0;
                bus.cpu_mem_write = 1'b0;
                #1;
                check("idle_stall", bus.cpu_stall, 1'b0);
                check("idle_sram_enable", bus.sram_enable, 1'b0);
            end
        end

        // Reset in the middle of a refill of set 15 (untouched so far, so no write-back).
        @(negedge clk);
        bus.cpu_addr = 32'h0000_29E0;
        bus.cpu_mem_read = 1'b1;
        bus.cpu_mem_write = 1'b0;
        begin
            int k;
            for (k = 0; k < 10; k++) begin
                @(negedge clk);
                #1;
                if (bus.mem_enable) break;
            end
            if (k == 10) fail_now("reset_wait_refill");
        end
        check("pre_rst_mem_write", bus.mem_write, 1'b0);
        rst_n = 1'b0;
        bus.cpu_mem_read = 1'b0;
        #1;
        check("midrst_mem_enable", bus.mem_enable, 1'b0);
        check("midrst_mem_addr", bus.mem_addr, 32'h0);
        check("midrst_stall", bus.cpu_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rd_data = {8{32'hBAD0_BAD0}};
        bus.mem_ack = 1'b1;
        #1;
        check("late_ack_sram", {bus.sram_enable, bus.sram_write}, 2'b00);
        check("late_ack_stall", bus.cpu_stall, 1'b0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("late_ack_mem_enable", bus.mem_enable, 1'b0);
        access(1'b0, 32'h0000_29E0, 32'h0, 1, rd, cyc);
        check("post_rst_rdata", rd, 32'h5A5A_29E0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
